// File: rtl/falling_block_array.sv
// Multi-slot falling block tracker: spawns into the lowest free slot, steps every
// live block down once per frame, retires or clears them and counts misses.
module falling_block_array #(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned Y_MAX    = 479,
  parameter int unsigned MAX_STEP = 7
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic                spawn_valid,
  input  logic [9:0]          spawn_x,
  output logic                spawn_ready,
  input  logic [2:0]          speed,
  input  logic                clear_valid,
  input  logic [2:0]          clear_slot,
  input  logic                level_done,
  output logic [10*SLOTS-1:0] BlockX,
  output logic [10*SLOTS-1:0] BlockY,
  output logic [SLOTS-1:0]    active,
  output logic [7:0]          miss_count,
  output logic                end_level
);
  logic [SLOTS-1:0] active_q, active_d;
  logic [9:0]       x_q [SLOTS];
  logic [9:0]       x_d [SLOTS];
  logic [9:0]       y_q [SLOTS];
  logic [9:0]       y_d [SLOTS];
  logic [7:0]       miss_q, miss_d;
  logic             end_q, end_d;
  logic [2:0]       step;
  logic [10:0]      y_sum [SLOTS];
  logic             spawn_acc;
  logic             spawn_taken;
  logic [3:0]       retire_cnt;
  logic [8:0]       miss_sum;

  assign spawn_ready = |(~active_q);
  assign spawn_acc   = spawn_valid && spawn_ready;
  assign step        = (32'(speed) > MAX_STEP) ? 3'(MAX_STEP) : speed;

  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      y_sum[i] = {1'b0, y_q[i]} + {8'b0, step};
    end
  end

  always_comb begin
    active_d    = active_q;
    x_d         = x_q;
    y_d         = y_q;
    end_d       = end_q;
    retire_cnt  = '0;
    spawn_taken = 1'b0;
    // Spawn only looks at slots free before this edge, so a slot freed now
    // by clear/retire cannot be reused until the next edge.
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (active_q[i]) begin
        if (clear_valid && (32'(clear_slot) == i)) begin
          active_d[i] = 1'b0;
        end else if (y_sum[i] > 11'(Y_MAX)) begin
          active_d[i] = 1'b0;
          retire_cnt  = retire_cnt + 4'd1;
        end else begin
          y_d[i] = y_sum[i][9:0];
        end
      end else if (spawn_acc && !spawn_taken) begin
        active_d[i] = 1'b1;
        x_d[i]      = spawn_x;
        y_d[i]      = '0;
        spawn_taken = 1'b1;
      end
    end
    miss_sum = {1'b0, miss_q} + {5'b0, retire_cnt};
    miss_d   = miss_sum[8] ? '1 : miss_sum[7:0];
    if (level_done && (active_q == '0) && !spawn_acc) begin
      end_d = 1'b1;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      active_q <= '0;
      miss_q   <= '0;
      end_q    <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      miss_q   <= miss_d;
      end_q    <= end_d;
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_pack
    assign BlockX[10*g +: 10] = x_q[g];
    assign BlockY[10*g +: 10] = y_q[g];
  end

  assign active     = active_q;
  assign miss_count = miss_q;
  assign end_level  = end_q;

endmodule

// File: tb/tb_falling_block_array.sv
// Bench for falling_block_array: behavioural slot model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_falling_block_array;
  localparam int SLOTS = 4;
  localparam int Y_MAX = 479;

  logic                clk = 1'b0;
  logic                Reset = 1'b0;
  logic                spawn_valid = 1'b0;
  logic [9:0]          spawn_x = '0;
  logic                spawn_ready;
  logic [2:0]          speed = '0;
  logic                clear_valid = 1'b0;
  logic [2:0]          clear_slot = '0;
  logic                level_done = 1'b0;
  logic [10*SLOTS-1:0] BlockX;
  logic [10*SLOTS-1:0] BlockY;
  logic [SLOTS-1:0]    active;
  logic [7:0]          miss_count;
  logic                end_level;

  falling_block_array #(.SLOTS(SLOTS), .Y_MAX(Y_MAX), .MAX_STEP(7)) dut (
    .frame_clk(clk), .Reset(Reset), .spawn_valid(spawn_valid), .spawn_x(spawn_x),
    .spawn_ready(spawn_ready), .speed(speed), .clear_valid(clear_valid),
    .clear_slot(clear_slot), .level_done(level_done), .BlockX(BlockX),
    .BlockY(BlockY), .active(active), .miss_count(miss_count), .end_level(end_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;
  bit lvl      = 1'b0;

  // Behavioural model of the block array
  int m_x [SLOTS];
  int m_y [SLOTS];
  bit m_act [SLOTS];
  int m_miss = 0;
  bit m_end  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int get_x(input int i);
    return int'(BlockX[10*i +: 10]);
  endfunction

  function automatic int get_y(input int i);
    return int'(BlockY[10*i +: 10]);
  endfunction

  task automatic model_edge(input bit rst, input bit sv, input int sx, input int spd,
                            input bit cv, input int cs, input bit ld);
    int nx [SLOTS];
    int ny [SLOTS];
    bit na [SLOTS];
    int retired;
    bit any_free, any_busy, accepted;
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_act[i] = 1'b0;
      end
      m_miss = 0;
      m_end  = 1'b0;
      return;
    end
    any_free = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (m_act[i]) any_busy = 1'b1;
      else          any_free = 1'b1;
    end
    accepted = sv && any_free;
    nx = m_x; ny = m_y; na = m_act;
    retired = 0;
    for (int i = 0; i < SLOTS; i++) begin
      if (m_act[i]) begin
        if (cv && cs == i) na[i] = 1'b0;
        else if (m_y[i] + spd > Y_MAX) begin
          na[i] = 1'b0;
          retired++;
        end else ny[i] = m_y[i] + spd;
      end
    end
    if (accepted) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (!m_act[i]) begin
          na[i] = 1'b1; nx[i] = sx; ny[i] = 0;
          break;
        end
      end
    end
    m_miss = (m_miss + retired > 255) ? 255 : m_miss + retired;
    if (ld && !any_busy && !accepted) m_end = 1'b1;
    m_x = nx; m_y = ny; m_act = na;
  endtask

  // One frame: drive inputs mid-cycle, advance model, return after the compare.
  task automatic step(input bit rst, input bit sv, input int sx, input int spd,
                      input bit cv, input int cs);
    @(negedge clk);
    Reset       = rst;
    spawn_valid = sv;
    spawn_x     = 10'(sx);
    speed       = 3'(spd);
    clear_valid = cv;
    clear_slot  = 3'(cs);
    level_done  = lvl;
    model_edge(rst, sv, sx, spd, cv, cs, lvl);
    if (rst) cmp_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic spawn(input int sx);
    step(1'b0, 1'b1, sx, 0, 1'b0, 0);
  endtask

  task automatic move(input int n, input int spd);
    repeat (n) step(1'b0, 1'b0, 0, spd, 1'b0, 0);
  endtask

  initial begin : compare_proc
    int rdy;
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        rdy = 0;
        for (int i = 0; i < SLOTS; i++) begin
          chk($sformatf("active[%0d]", i), int'(active[i]), int'(m_act[i]));
          chk($sformatf("BlockX[%0d]", i), get_x(i), m_x[i]);
          chk($sformatf("BlockY[%0d]", i), get_y(i), m_y[i]);
          if (!m_act[i]) rdy = 1;
        end
        chk("miss_count", int'(miss_count), m_miss);
        chk("end_level", int'(end_level), int'(m_end));
        chk("spawn_ready", int'(spawn_ready), rdy);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    // Reset state
    do_reset();
    chk("rst active", int'(active), 0);
    chk("rst ready", int'(spawn_ready), 1);
    chk("rst miss", int'(miss_count), 0);

    // Single block falls off the bottom at speed 1
    step(1'b0, 1'b1, 200, 1, 1'b0, 0);
    chk("t1 act0", int'(active[0]), 1);
    chk("t1 x0", get_x(0), 200);
    chk("t1 y0", get_y(0), 0);
    move(479, 1);
    chk("t1 y479", get_y(0), 479);
    chk("t1 still act", int'(active[0]), 1);
    move(1, 1);
    chk("t1 retired", int'(active[0]), 0);
    chk("t1 miss", int'(miss_count), 1);
    chk("t1 y hold", get_y(0), 479);

    // Fill all slots; fifth spawn rejected
    do_reset();
    spawn(100); spawn(200); spawn(300); spawn(400);
    chk("t2 full", int'(active), 15);
    chk("t2 ready", int'(spawn_ready), 0);
    chk("t2 x3", get_x(3), 400);
    spawn(999);
    chk("t2 x0 kept", get_x(0), 100);
    chk("t2 x2 kept", get_x(2), 300);

    // Overflow retire without wrap, and in-range landing on 479
    do_reset();
    spawn(500);
    move(119, 4);
    chk("t3 y476", get_y(0), 476);
    move(1, 7);
    chk("t3 retire", int'(active[0]), 0);
    chk("t3 no wrap", get_y(0), 476);
    do_reset();
    spawn(500);
    move(119, 4);
    move(1, 3);
    chk("t3 y479", get_y(0), 479);
    chk("t3 alive", int'(active[0]), 1);

    // Clear beats retire; freed slot reused next edge
    do_reset();
    spawn(10); spawn(11); spawn(12);
    step(1'b0, 1'b0, 0, 0, 1'b1, 0);
    step(1'b0, 1'b0, 0, 0, 1'b1, 1);
    move(119, 4);
    spawn(20); spawn(21);
    step(1'b0, 1'b0, 0, 7, 1'b1, 2);
    chk("t4 slot2 off", int'(active[2]), 0);
    chk("t4 miss", int'(miss_count), 0);
    spawn(77);
    chk("t4 slot2 reuse", int'(active[2]), 1);
    chk("t4 x2", get_x(2), 77);

    // end_level behaviour
    do_reset();
    lvl = 1'b1;
    spawn(10); spawn(20);
    move(119, 4);
    move(1, 7);
    chk("t5 end low", int'(end_level), 0);
    chk("t5 miss2", int'(miss_count), 2);
    move(1, 0);
    chk("t5 end high", int'(end_level), 1);
    lvl = 1'b0;
    move(1, 0);
    spawn(5);
    chk("t5 end sticky", int'(end_level), 1);
    do_reset();
    chk("t5 end reset", int'(end_level), 0);

    // Reset with live blocks and a nonzero miss count
    spawn(1); spawn(2); spawn(3); spawn(4);
    move(119, 4);
    move(1, 7);
    spawn(9);
    move(119, 4);
    move(1, 7);
    chk("t6 miss5", int'(miss_count), 5);
    spawn(1); spawn(2); spawn(3);
    step(1'b1, 1'b1, 123, 5, 1'b1, 0);
    chk("t6 active", int'(active), 0);
    chk("t6 miss", int'(miss_count), 0);
    chk("t6 ready", int'(spawn_ready), 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) lvl = ~lvl;
      step($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)),
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 7)));
    end

    // Miss counter saturation
    lvl = 1'b0;
    do_reset();
    for (int n = 0; n < 5000; n++) begin
      step(1'b0, 1'b1, int'($urandom_range(0, 1023)), 7, 1'b0, 0);
    end
    chk("t7 saturate", int'(miss_count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
